// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between the instruction-fetch
// requester (I) and the load/store requester (D). The grant is combinational.
// The RAM's one-cycle read data is steered back to the winner with a
// registered valid pulse.
module bram_port_arbiter #(
    parameter int DATA = 8,
    parameter int ADDR = 16
) (
    input  logic            clk,
    input  logic            rst,
    // instruction-fetch requester
    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DATA-1:0] i_rdata,
    // load/store requester
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [ADDR-1:0] d_addr,
    input  logic [DATA-1:0] d_din,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DATA-1:0] d_rdata,
    // RAM port
    output logic            m_wr,
    output logic [ADDR-1:0] m_addr,
    output logic [DATA-1:0] m_din,
    input  logic [DATA-1:0] m_dout
);

    // Which requester owns the response that the RAM returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    own_t            r_own;
    own_t            w_own_next;
    logic            r_prio;        // 0: I favoured on a tie, 1: D favoured
    logic            w_prio_next;
    logic [ADDR-1:0] r_addr_hold;   // last address driven, reused while idle
    logic [DATA-1:0] r_din_hold;    // last write data driven, reused while idle
    logic            w_i_gnt;
    logic            w_d_gnt;

    // Grant selection: a lone requester wins; a tie goes to the favoured side.
    // Nothing is granted while reset is asserted.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!rst) begin
            w_i_gnt = i_req && (!d_req || !r_prio);
            w_d_gnt = d_req && (!i_req ||  r_prio);
        end
    end

    // Next priority and owner: favour the loser of this cycle; tag the response.
    always_comb begin
        w_prio_next = r_prio;
        w_own_next  = OWN_NONE;
        if (w_i_gnt) begin
            w_prio_next = 1'b1;
            w_own_next  = OWN_I;
        end else if (w_d_gnt) begin
            w_prio_next = 1'b0;
            w_own_next  = OWN_D;
        end
    end

    // State registers: priority pointer, response owner, idle hold values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= 1'b0;
            r_own       <= OWN_NONE;
            r_addr_hold <= '0;
            r_din_hold  <= '0;
        end else begin
            r_prio      <= w_prio_next;
            r_own       <= w_own_next;
            r_addr_hold <= m_addr;
            r_din_hold  <= m_din;
        end
    end

    // RAM port drive: the winner's address and data; write only for a D store.
    always_comb begin
        m_addr = r_addr_hold;
        m_din  = r_din_hold;
        m_wr   = 1'b0;
        if (w_i_gnt) begin
            m_addr = i_addr;
        end else if (w_d_gnt) begin
            m_addr = d_addr;
            m_din  = d_din;
            m_wr   = d_wr;
        end
    end

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = (r_own == OWN_I);
    assign d_rvalid = (r_own == OWN_D);
    // Read data is shared; it is meaningful only alongside the matching rvalid.
    assign i_rdata  = m_dout;
    assign d_rdata  = m_dout;

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of the dual-port block RAM between the CPU's instruction-fetch requester (I) and load/store requester (D). It selects at most one request per cycle and drives the RAM port's address, write strobe and write data. It then routes the RAM's one-cycle-latency output back to the winning requester, tagged with a response-valid strobe. It sits between the CPU core and BRAM port A; port B stays free for the loader/debug path.

## Interface
- DATA, 8, data width; must match the RAM's DATA
- ADDR, 16, address width; must match the RAM's ADDR
- clk  in  1  single clock for the arbiter and the RAM port it drives
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with stable i_addr until i_gnt
- i_addr  in  ADDR  fetch address
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid (registered pulse)
- i_rdata  out  DATA  fetch data; valid only while i_rvalid
- d_req  in  1  load/store request; held with stable d_wr/d_addr/d_din until d_gnt
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  ADDR  load/store address
- d_din  in  DATA  store data
- d_gnt  out  1  load/store accepted this cycle (combinational)
- d_rvalid  out  1  load data, or store acknowledge, valid (registered pulse)
- d_rdata  out  DATA  load data; for a store, the written data (write-first RAM)
- m_wr  out  1  RAM write strobe
- m_addr  out  ADDR  RAM address
- m_din  out  DATA  RAM write data
- m_dout  in  DATA  RAM read data, one cycle after address

## Operation
- Priority pointer `prio` (1 bit: 0 = I favoured, 1 = D favoured). Reset value 0.
- Grant logic, combinational, gated by !rst:
  - Only one requester asserting: it wins.
  - Both asserting: the favoured one wins.
  - Neither asserting: no grant.
- Exactly zero or one of i_gnt/d_gnt is high in any cycle.
- On a grant, prio is set to favour the loser on the next cycle: I wins → prio=1, D wins → prio=0. With no grant, prio holds.
- Memory drive:
  - I wins: m_addr=i_addr, m_wr=0.
  - D wins: m_addr=d_addr, m_wr=d_wr, m_din=d_din.
  - No grant: m_wr=0; m_addr/m_din hold their previous registered-source value (don't care, but m_wr must be 0).
- Response tracking:
  - Registered owner tag `own` ∈ {NONE, I, D}, loaded every cycle from the grant. Reset NONE.
  - Next cycle: own=I → i_rvalid=1, i_rdata=m_dout; own=D → d_rvalid=1, d_rdata=m_dout.
  - rdata outputs are plain wires from m_dout; valid only with rvalid.
- No outstanding-request limit. A requester may be granted on consecutive cycles, and responses return in grant order, one per cycle.
- A request deasserted before grant is dropped silently; no response is produced.

## Timing
- Grant in cycle N (same cycle as req) → rvalid for that requester in cycle N+1, exactly one cycle wide.
- Throughput is one transaction per cycle total. With both requesting continuously, grants alternate I, D, I, D…
- Each requester gets at least one grant in every two cycles while requesting, so there is no starvation.
- Reset:
  - While rst=1: i_gnt=d_gnt=0 and m_wr=0.
  - After the first clock edge with rst=1: i_rvalid=d_rvalid=0, own=NONE, prio=0.
  - A grant in the cycle before rst rises produces no rvalid if rst is sampled at that edge; the in-flight response is discarded.
- Store followed by load to the same address on consecutive D grants: the load returns the new data (RAM write-first, single port).
- Simultaneous I and D to the same address: serialized by the arbiter; no collision handling needed.

## Test plan
- After reset, with i_req=1 (addr 0x0010) and d_req=0: i_gnt=1 in the same cycle, m_addr=0x0010, m_wr=0. The next cycle shows i_rvalid=1 with i_rdata equal to mem[0x0010]; d_rvalid stays 0.
- i_req and d_req both held high for 6 cycles from reset: grant sequence I, D, I, D, I, D. rvalid pulses follow one cycle later in the same order, never both high.
- D store 0xA5 to 0x0100, then D load from 0x0100 on the next cycle:
  - Store cycle: m_wr=1, m_din=0xA5.
  - d_rvalid with d_rdata=0xA5 on both response cycles.
- Only D requesting for 4 consecutive cycles: d_gnt=1 every cycle and d_rvalid=1 for 4 consecutive cycles. prio=0 afterwards, so I wins the next tie.
- Grant I in cycle N, assert rst in cycle N: i_rvalid=0 in N+1, and gnt=0/m_wr=0 for the whole reset duration. First grant after release goes to I on a tie.
- d_req asserted for one cycle while I wins the tie, then dropped: no d_gnt, no d_rvalid, no m_wr pulse.
